// File: rtl/gpr_file_mp.sv
// gpr_file_mp: parametrised general-purpose register file.
// NUM_RD combinational read ports with write-to-read bypass, two write ports
// (main writeback + link/auxiliary), a per-register busy scoreboard for
// decode stalls, and a sticky flag for same-index dual writes.
`timescale 1ns/1ps

module gpr_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  input  logic                       claim_en,
  input  logic [ADDR_W-1:0]          claim_addr,
  output logic [(2**ADDR_W)-1:0]     busy_vec,
  output logic                       wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  // Effective write/claim strobes: anything aimed at a hard-wired zero
  // register is dropped here so nothing downstream needs to special-case it.
  logic              wr0_act;
  logic              wr1_act;
  logic              claim_act;
  logic              conflict_now;

  // One-hot decode of each write port and the claim, per register.
  logic [DEPTH-1:0]  wr0_hit;
  logic [DEPTH-1:0]  wr1_hit;
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  claim_hit;

  // Architectural state.
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              conflict_q;

  // Per-port read index, unpacked for readability.
  logic [ADDR_W-1:0] rd_idx [NUM_RD];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_idx
    assign rd_idx[k] = rd_addr[k*ADDR_W +: ADDR_W];
  end

  // Qualify write and claim strobes against the zero-register rule.
  always_comb begin
    wr0_act      = we0      && !((ZERO_REG != 0) && (waddr0     == '0));
    wr1_act      = we1      && !((ZERO_REG != 0) && (waddr1     == '0));
    claim_act    = claim_en && !((ZERO_REG != 0) && (claim_addr == '0));
    conflict_now = wr0_act && wr1_act && (waddr0 == waddr1);
  end

  // Decode write ports and the claim into per-register hit vectors.
  always_comb begin
    wr0_hit   = '0;
    wr1_hit   = '0;
    claim_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr0_hit[i]   = wr0_act   && (waddr0     == ADDR_W'(i));
      wr1_hit[i]   = wr1_act   && (waddr1     == ADDR_W'(i));
      claim_hit[i] = claim_act && (claim_addr == ADDR_W'(i));
    end
    wr_hit = wr0_hit | wr1_hit;
  end

  // Register storage: port 0 has priority when both ports target one index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr0_hit[i]) begin
          regs[i] <= wdata0;
        end else if (wr1_hit[i]) begin
          regs[i] <= wdata1;
        end
      end
    end
  end

  // Scoreboard next state: a write releases, a claim sets, and a claim in
  // the same cycle as a write to that index wins (the new producer is pending).
  always_comb begin
    busy_d = (busy_q & ~wr_hit) | claim_hit;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Sticky dual-write collision flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
    end else if (conflict_now) begin
      conflict_q <= 1'b1;
    end
  end

  // Combinational read ports with bypass; the zero register overrides bypass,
  // and a register being written this cycle is never reported as busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if ((ZERO_REG != 0) && (rd_idx[k] == '0)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else if (wr0_act && (waddr0 == rd_idx[k])) begin
        rd_data[k*DATA_W +: DATA_W] = wdata0;
      end else if (wr1_act && (waddr1 == rd_idx[k])) begin
        rd_data[k*DATA_W +: DATA_W] = wdata1;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = regs[rd_idx[k]];
      end
      rd_busy[k] = busy_q[rd_idx[k]] && !wr_hit[rd_idx[k]];
    end
  end

  assign busy_vec    = busy_q;
  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_gpr_file_mp.sv
// Testbench for gpr_file_mp: a default 32x32 / 2-read instance with a zero
// register, and a 16x64 / 4-read instance with an ordinary register 0.
`timescale 1ns/1ps

module tb_gpr_file_mp;

  logic clk = 1'b0;
  logic rst_n;

  // Default instance
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we0, we1, claim_en;
  logic [4:0]  waddr0, waddr1, claim_addr;
  logic [31:0] wdata0, wdata1;
  logic [31:0] busy_vec;
  logic        wr_conflict;

  // Wide instance
  logic [15:0]  w_rd_addr;
  logic [255:0] w_rd_data;
  logic [3:0]   w_rd_busy;
  logic         w_we0, w_we1, w_claim_en;
  logic [3:0]   w_waddr0, w_waddr1, w_claim_addr;
  logic [63:0]  w_wdata0, w_wdata1;
  logic [15:0]  w_busy_vec;
  logic         w_wr_conflict;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  bit          m_conf;
  logic [63:0] x_mem  [16];
  bit          x_busy [16];
  bit          x_conf;

  always #5 clk = ~clk;

  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_vec(busy_vec), .wr_conflict(wr_conflict)
  );

  gpr_file_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(0)) u_wide (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .we0(w_we0), .waddr0(w_waddr0), .wdata0(w_wdata0),
    .we1(w_we1), .waddr1(w_waddr1), .wdata1(w_wdata1),
    .claim_en(w_claim_en), .claim_addr(w_claim_addr),
    .busy_vec(w_busy_vec), .wr_conflict(w_wr_conflict)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rd_addr = '0; we0 = 0; we1 = 0; claim_en = 0;
    waddr0 = '0; waddr1 = '0; claim_addr = '0; wdata0 = '0; wdata1 = '0;
    w_rd_addr = '0; w_we0 = 0; w_we1 = 0; w_claim_en = 0;
    w_waddr0 = '0; w_waddr1 = '0; w_claim_addr = '0; w_wdata0 = '0; w_wdata1 = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    for (int i = 0; i < 16; i++) begin x_mem[i] = '0; x_busy[i] = 0; end
    m_conf = 0;
    x_conf = 0;
  endtask

  // One clock: the model forms "what each register holds after this edge"
  // (port 1 applied, then port 0 on top). A same-cycle read must already see
  // that value; busy is shown only for registers not written this cycle.
  task automatic cycle();
    logic [31:0] nx  [32];
    bit          wr  [32];
    logic [63:0] xnx [16];
    bit          xwr [16];
    logic [4:0]  a;
    logic [3:0]  b;
    logic [31:0] bv;
    logic [15:0] xbv;
    #1;
    nx = m_mem;
    for (int i = 0; i < 32; i++) wr[i] = 0;
    if (we1 && waddr1 != 0) begin nx[waddr1] = wdata1; wr[waddr1] = 1; end
    if (we0 && waddr0 != 0) begin nx[waddr0] = wdata0; wr[waddr0] = 1; end
    for (int k = 0; k < 2; k++) begin
      a = rd_addr[k*5 +: 5];
      chk($sformatf("rd_data%0d[r%0d]", k, a), rd_data[k*32 +: 32], nx[a]);
      chk($sformatf("rd_busy%0d[r%0d]", k, a), rd_busy[k], m_busy[a] && !wr[a]);
    end
    xnx = x_mem;
    for (int i = 0; i < 16; i++) xwr[i] = 0;
    if (w_we1) begin xnx[w_waddr1] = w_wdata1; xwr[w_waddr1] = 1; end
    if (w_we0) begin xnx[w_waddr0] = w_wdata0; xwr[w_waddr0] = 1; end
    for (int k = 0; k < 4; k++) begin
      b = w_rd_addr[k*4 +: 4];
      chk($sformatf("w_rd_data%0d[r%0d]", k, b), w_rd_data[k*64 +: 64], xnx[b]);
      chk($sformatf("w_rd_busy%0d[r%0d]", k, b), w_rd_busy[k], x_busy[b] && !xwr[b]);
    end
    @(posedge clk);
    #1;
    m_mem = nx;
    for (int i = 0; i < 32; i++) if (wr[i]) m_busy[i] = 0;
    if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1;
    if (we0 && we1 && waddr0 == waddr1 && waddr0 != 0) m_conf = 1;
    x_mem = xnx;
    for (int i = 0; i < 16; i++) if (xwr[i]) x_busy[i] = 0;
    if (w_claim_en) x_busy[w_claim_addr] = 1;
    if (w_we0 && w_we1 && w_waddr0 == w_waddr1) x_conf = 1;
    for (int i = 0; i < 32; i++) bv[i] = m_busy[i];
    for (int i = 0; i < 16; i++) xbv[i] = x_busy[i];
    chk("busy_vec", busy_vec, bv);
    chk("wr_conflict", wr_conflict, m_conf);
    chk("w_busy_vec", w_busy_vec, xbv);
    chk("w_wr_conflict", w_wr_conflict, x_conf);
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    we0 = 1'($urandom_range(0, 1));
    we1 = 1'($urandom_range(0, 1));
    waddr0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    waddr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    wdata0 = $urandom;
    wdata1 = $urandom;
    if (we0 && we1 && waddr0 == 0 && waddr1 == 0) we1 = 0;
    claim_en = ($urandom_range(0, 2) == 0);
    claim_addr = 5'($urandom_range(0, 7));
    rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
    w_we0 = 1'($urandom_range(0, 1));
    w_we1 = 1'($urandom_range(0, 1));
    w_waddr0 = 4'($urandom_range(0, 15));
    w_waddr1 = 4'($urandom_range(0, 15));
    w_wdata0 = {$urandom, $urandom};
    w_wdata1 = {$urandom, $urandom};
    w_claim_en = ($urandom_range(0, 2) == 0);
    w_claim_addr = 4'($urandom_range(0, 15));
    w_rd_addr = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    rd_addr = {5'd0, 5'd5};
    #1;
    chk("reset_rd_r5", rd_data[31:0], 32'h0);
    chk("reset_busy_vec", busy_vec, 32'h0);
    chk("reset_conflict", wr_conflict, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write/read, zero register
    idle(); we0 = 1; waddr0 = 5'd3; wdata0 = 32'h12345678; cycle();
    idle(); rd_addr = {5'd0, 5'd3}; #1;
    chk("basic_r3", rd_data[31:0], 32'h12345678); cycle();
    idle(); we0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF; rd_addr = {5'd0, 5'd0}; #1;
    chk("r0_write_bypass", rd_data[31:0], 32'h0); cycle();
    idle(); #1;
    chk("r0_after_write", rd_data[31:0], 32'h0); cycle();

    // Bypass
    idle(); we0 = 1; waddr0 = 5'd7; wdata0 = 32'hA5A5A5A5; rd_addr = {5'd7, 5'd3}; #1;
    chk("bypass_p1_r7", rd_data[63:32], 32'hA5A5A5A5);
    chk("bypass_p0_r3", rd_data[31:0], 32'h12345678); cycle();

    // Dual write, distinct indices
    idle(); we0 = 1; waddr0 = 5'd4; wdata0 = 32'h4; we1 = 1; waddr1 = 5'd31; wdata1 = 32'h100; cycle();
    idle(); rd_addr = {5'd31, 5'd4}; #1;
    chk("dual_r4", rd_data[31:0], 32'h4);
    chk("dual_r31", rd_data[63:32], 32'h100);
    chk("dual_no_conflict", wr_conflict, 1'b0); cycle();

    // Same-index dual write
    idle(); we0 = 1; waddr0 = 5'd7; wdata0 = 32'h1111; we1 = 1; waddr1 = 5'd7; wdata1 = 32'h2222;
    rd_addr = {5'd7, 5'd7}; #1;
    chk("conflict_bypass_p0", rd_data[31:0], 32'h1111);
    chk("conflict_bypass_p1", rd_data[63:32], 32'h1111); cycle();
    idle(); rd_addr = {5'd0, 5'd7}; #1;
    chk("conflict_stored_r7", rd_data[31:0], 32'h1111);
    chk("conflict_set", wr_conflict, 1'b1); cycle(); cycle();
    chk("conflict_sticky", wr_conflict, 1'b1);

    // Scoreboard
    idle(); claim_en = 1; claim_addr = 5'd9; cycle();
    idle(); rd_addr = {5'd0, 5'd9}; #1;
    chk("claim_rd_busy", rd_busy[0], 1'b1);
    chk("claim_busy_vec9", busy_vec[9], 1'b1); cycle();
    idle(); we0 = 1; waddr0 = 5'd9; wdata0 = 32'h55; rd_addr = {5'd0, 5'd9}; #1;
    chk("release_rd_busy", rd_busy[0], 1'b0);
    chk("release_bypass", rd_data[31:0], 32'h55); cycle();
    chk("release_busy_vec9", busy_vec[9], 1'b0);
    idle(); claim_en = 1; claim_addr = 5'd9; we1 = 1; waddr1 = 5'd9; wdata1 = 32'h66; cycle();
    chk("claim_wins_busy_vec9", busy_vec[9], 1'b1);
    idle(); rd_addr = {5'd0, 5'd9}; #1;
    chk("claim_wins_data", rd_data[31:0], 32'h66);
    chk("claim_wins_rd_busy", rd_busy[0], 1'b1); cycle();
    idle(); claim_en = 1; claim_addr = 5'd0; cycle();
    chk("claim_r0_dropped", busy_vec[0], 1'b0);

    // Wide instance: 64-bit data, four ports, ordinary register 0
    idle(); w_we0 = 1; w_waddr0 = 4'd5; w_wdata0 = 64'h0123456789ABCDEF;
    w_we1 = 1; w_waddr1 = 4'd0; w_wdata1 = 64'hFFFFFFFFFFFFFFFF; cycle();
    idle(); w_we0 = 1; w_waddr0 = 4'd2; w_wdata0 = 64'hA; w_we1 = 1; w_waddr1 = 4'd15; w_wdata1 = 64'hB;
    w_claim_en = 1; w_claim_addr = 4'd3; cycle();
    idle(); w_rd_addr = {4'd3, 4'd15, 4'd0, 4'd5}; #1;
    chk("wide_p0_r5", w_rd_data[63:0], 64'h0123456789ABCDEF);
    chk("wide_p1_r0", w_rd_data[127:64], 64'hFFFFFFFFFFFFFFFF);
    chk("wide_p2_r15", w_rd_data[191:128], 64'hB);
    chk("wide_p3_r3", w_rd_data[255:192], 64'h0);
    chk("wide_p3_busy", w_rd_busy, 4'b1000);
    chk("wide_busy_vec", w_busy_vec, 16'h0008); cycle();

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      cycle();
    end

    // Asynchronous reset mid-run
    idle(); we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; claim_en = 1; claim_addr = 5'd6;
    we1 = 1; waddr1 = 5'd8; wdata1 = 32'h1; cycle();
    idle(); claim_en = 1; claim_addr = 5'd6; w_claim_en = 1; w_claim_addr = 4'd6;
    rd_addr = {5'd0, 5'd5};
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_r5", rd_data[31:0], 32'h0);
    chk("async_rst_busy_vec", busy_vec, 32'h0);
    chk("async_rst_conflict", wr_conflict, 1'b0);
    chk("async_rst_w_busy_vec", w_busy_vec, 16'h0);
    @(posedge clk); #1;
    chk("rst_held_busy_vec", busy_vec, 32'h0);
    chk("rst_held_w_busy_vec", w_busy_vec, 16'h0);
    @(negedge clk);
    idle();
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 100; n++) begin
      rand_inputs();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
